// File: rtl/rom_rd_arb.sv
// Purpose: lets three ROM byte requesters share one toggle-handshake SDRAM word read port, with a one-word cache per requester.
// Latency: a hit is combinational; a miss reaches valid 2 cycles plus the SDRAM ack latency after it appears.
// Backpressure: one fetch is in flight at a time with no timeout; a slow ack holds the arbiter and the other misses keep valid low.
module rom_rd_arb #(
  parameter int              AW    = 22,
  parameter logic [AW-1:0]   BASE0 = 22'h000000,
  parameter logic [AW-1:0]   BASE1 = 22'h007000,
  parameter logic [AW-1:0]   BASE2 = 22'h008000
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_busy,
  input  logic [AW:0]   rq0_addr,
  input  logic [AW:0]   rq1_addr,
  input  logic [AW:0]   rq2_addr,
  output logic [7:0]    rq0_dout,
  output logic [7:0]    rq1_dout,
  output logic [7:0]    rq2_dout,
  output logic          rq0_valid,
  output logic          rq1_valid,
  output logic          rq2_valid,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_addr,
  input  logic [15:0]   mem_q
);

  localparam logic [1:0] ST_RESYNC = 2'd0;
  localparam logic [1:0] ST_IDLE   = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;

  // Round-robin successor over the three requesters.
  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  logic [1:0]          state;
  logic [1:0]          rr;
  logic [1:0]          grant;
  logic [1:0]          pick;
  logic [1:0]          cand;
  logic                any_pend;
  logic [AW-1:0]       issue_word;
  logic [AW-1:0]       pick_word;
  logic [AW-1:0]       pick_base;
  logic [AW-1:0]       fetch_addr;
  logic                ack_seen;
  logic                issue;
  logic                fill;

  logic [2:0][15:0]    cache_dat;
  logic [2:0][AW-1:0]  tag;
  logic [2:0]          tag_vld;
  logic [2:0][AW-1:0]  word_addr;
  logic [2:0][AW-1:0]  base;
  logic [2:0]          byte_sel;
  logic [2:0]          hit;
  logic [2:0]          pending;

  // The request toggle is never touched by reset: an outstanding toggle must
  // be matched by the SDRAM side before the port is reused.
  logic                req_tgl = 1'b0;

  assign word_addr[0] = rq0_addr[AW:1];
  assign word_addr[1] = rq1_addr[AW:1];
  assign word_addr[2] = rq2_addr[AW:1];
  assign byte_sel     = {rq2_addr[0], rq1_addr[0], rq0_addr[0]};
  assign base[0]      = BASE0;
  assign base[1]      = BASE1;
  assign base[2]      = BASE2;

  // Cache hit per requester: tag valid and tag equal to the live word address.
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i] = tag_vld[i] & (tag[i] == word_addr[i]);
    end
  end

  assign pending   = ~hit;
  assign rq0_valid = hit[0];
  assign rq1_valid = hit[1];
  assign rq2_valid = hit[2];
  assign rq0_dout  = byte_sel[0] ? cache_dat[0][15:8] : cache_dat[0][7:0];
  assign rq1_dout  = byte_sel[1] ? cache_dat[1][15:8] : cache_dat[1][7:0];
  assign rq2_dout  = byte_sel[2] ? cache_dat[2][15:8] : cache_dat[2][7:0];

  // Search rr, rr+1, rr+2 (mod 3); the first pending requester wins.
  always_comb begin
    pick     = rr;
    any_pend = 1'b0;
    cand     = rr;
    for (int k = 0; k < 3; k++) begin
      if (!any_pend && pending[cand]) begin
        pick     = cand;
        any_pend = 1'b1;
      end
      cand = inc3(cand);
    end
  end

  // Select the winner's untranslated word address and its region offset.
  always_comb begin
    pick_word = '0;
    pick_base = '0;
    for (int i = 0; i < 3; i++) begin
      if (pick == 2'(i)) begin
        pick_word = word_addr[i];
        pick_base = base[i];
      end
    end
  end

  // Translation wraps modulo 2^AW by truncation.
  assign fetch_addr = pick_word + pick_base;

  assign ack_seen = (mem_ack == req_tgl);
  assign issue    = (state == ST_IDLE) && !dl_busy && any_pend;
  assign fill     = (state == ST_WAIT) && ack_seen;
  assign mem_req  = req_tgl;

  // Arbiter FSM: drain any stale toggle, issue one fetch, wait for its ack.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= ST_RESYNC;
      rr         <= 2'd0;
      grant      <= 2'd0;
      issue_word <= '0;
      mem_addr   <= '0;
    end else begin
      case (state)
        ST_RESYNC: begin
          if (ack_seen) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (issue) begin
            grant      <= pick;
            issue_word <= pick_word;
            mem_addr   <= fetch_addr;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (ack_seen) begin
            rr    <= inc3(grant);
            state <= ST_IDLE;
          end
        end
        default: state <= ST_RESYNC;
      endcase
    end
  end

  // Request toggle flips once per issued fetch; reset leaves it alone.
  always_ff @(posedge clk_sys) begin
    if (!reset && issue) req_tgl <= ~req_tgl;
  end

  // Cache fill on ack under the tag captured at issue; download wipes validity.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cache_dat <= '0;
      tag       <= '0;
      tag_vld   <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (fill && grant == 2'(i)) begin
          cache_dat[i] <= mem_q;
          tag[i]       <= issue_word;
          tag_vld[i]   <= ~dl_busy;
        end
      end
      if (dl_busy) tag_vld <= '0;
    end
  end

endmodule

// File: tb/tb_rom_rd_arb.sv
// Directed bench for rom_rd_arb: hand-computed addresses and data per step.
// A simple SDRAM responder is driven step by step from the main sequence.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_rom_rd_arb;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        dl_busy;
  logic [22:0] rq0_addr, rq1_addr, rq2_addr;
  logic [7:0]  rq0_dout, rq1_dout, rq2_dout;
  logic        rq0_valid, rq1_valid, rq2_valid;
  logic        mem_req;
  logic        mem_ack;
  logic [21:0] mem_addr;
  logic [15:0] mem_q;

  int n_cmp = 0;
  int n_bad = 0;
  logic exp_req = 1'b0;

  rom_rd_arb dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .dl_busy   (dl_busy),
    .rq0_addr  (rq0_addr),
    .rq1_addr  (rq1_addr),
    .rq2_addr  (rq2_addr),
    .rq0_dout  (rq0_dout),
    .rq1_dout  (rq1_dout),
    .rq2_dout  (rq2_dout),
    .rq0_valid (rq0_valid),
    .rq1_valid (rq1_valid),
    .rq2_valid (rq2_valid),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .mem_addr  (mem_addr),
    .mem_q     (mem_q)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for a new request toggle, then check toggle level and address.
  task automatic wait_req(input logic [21:0] exp_addr, input string tag);
    bit seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_sys);
      if (mem_req !== mem_ack) begin
        seen = 1;
        break;
      end
    end
    exp_req = ~exp_req;
    check({tag, "_seen"}, 32'(seen), 32'd1);
    check({tag, "_req"},  32'(mem_req), 32'(exp_req));
    check({tag, "_addr"}, 32'(mem_addr), 32'(exp_addr));
  endtask

  // Return data with the ack toggle; leaves us at the negedge after the fill edge.
  task automatic give_ack(input logic [15:0] q);
    mem_q   = q;
    mem_ack = ~mem_ack;
    @(posedge clk_sys);
    @(negedge clk_sys);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  initial begin
    reset    = 1'b1;
    dl_busy  = 1'b0;
    mem_ack  = 1'b0;
    mem_q    = 16'h0000;
    rq0_addr = 23'h000011;
    rq1_addr = 23'h000004;
    rq2_addr = 23'h000000;
    idle_cycles(3);

    // Reset state
    check("rst_v0", 32'(rq0_valid), 32'd0);
    check("rst_v1", 32'(rq1_valid), 32'd0);
    check("rst_v2", 32'(rq2_valid), 32'd0);
    check("rst_d0", 32'(rq0_dout), 32'h00);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);

    // Single fetch, byte select, hit without new request; rr=0 so order 0,1,2
    reset = 1'b0;
    wait_req(22'h000008, "t1_rq0");
    give_ack(16'hBEEF);
    check("t1_v0", 32'(rq0_valid), 32'd1);
    check("t1_d0_hi", 32'(rq0_dout), 32'hBE);
    rq0_addr = 23'h000010;
    #1;
    check("t1_v0_lo", 32'(rq0_valid), 32'd1);
    check("t1_d0_lo", 32'(rq0_dout), 32'hEF);
    wait_req(22'h007002, "t2_rq1");
    give_ack(16'h1234);
    wait_req(22'h008000, "t2_rq2");
    give_ack(16'h5678);
    check("t2_v0", 32'(rq0_valid), 32'd1);
    check("t2_v1", 32'(rq1_valid), 32'd1);
    check("t2_d1", 32'(rq1_dout), 32'h34);
    check("t2_v2", 32'(rq2_valid), 32'd1);
    check("t2_d2", 32'(rq2_dout), 32'h78);
    idle_cycles(5);
    check("t2_quiet", 32'(mem_req), 32'(exp_req));

    // Address change while waiting: fill lands under the old tag
    rq1_addr = 23'h00000A;
    wait_req(22'h007005, "t3_pre");
    give_ack(16'h0F0F);
    rq1_addr = 23'h000004;
    wait_req(22'h007002, "t3_old");
    rq1_addr = 23'h000006;
    give_ack(16'hAAAA);
    check("t3_v1_stale", 32'(rq1_valid), 32'd0);
    wait_req(22'h007003, "t3_new");
    give_ack(16'hCCDD);
    check("t3_v1", 32'(rq1_valid), 32'd1);
    check("t3_d1", 32'(rq1_dout), 32'hDD);
    check("t3_v0", 32'(rq0_valid), 32'd1);

    // Download during a fetch: everything invalid, nothing issued until it ends
    rq2_addr = 23'h000002;
    wait_req(22'h008001, "t4_rq2");
    dl_busy = 1'b1;
    @(negedge clk_sys);
    check("t4_v0", 32'(rq0_valid), 32'd0);
    check("t4_v1", 32'(rq1_valid), 32'd0);
    check("t4_v2", 32'(rq2_valid), 32'd0);
    give_ack(16'h9999);
    idle_cycles(5);
    check("t4_noissue", 32'(mem_req), 32'(exp_req));
    check("t4_v2_disc", 32'(rq2_valid), 32'd0);
    dl_busy = 1'b0;
    wait_req(22'h000008, "t4_r0");
    give_ack(16'h1111);
    check("t4_d0", 32'(rq0_dout), 32'h11);
    wait_req(22'h007003, "t4_r1");
    give_ack(16'h2222);
    wait_req(22'h008001, "t4_r2");
    give_ack(16'h3333);
    check("t4_v2", 32'(rq2_valid), 32'd1);
    check("t4_d2", 32'(rq2_dout), 32'h33);

    // Reset while a fetch is outstanding: toggle kept, drained before reuse
    rq0_addr = 23'h000020;
    wait_req(22'h000010, "t5_pre");
    check("t5_req_hi", 32'(mem_req), 32'd1);
    reset = 1'b1;
    idle_cycles(2);
    check("t5_v0", 32'(rq0_valid), 32'd0);
    check("t5_v1", 32'(rq1_valid), 32'd0);
    check("t5_d0", 32'(rq0_dout), 32'h00);
    reset = 1'b0;
    idle_cycles(5);
    check("t5_req_hold", 32'(mem_req), 32'd1);
    check("t5_addr_rst", 32'(mem_addr), 32'd0);
    mem_ack = 1'b1;
    wait_req(22'h000010, "t5_r0");
    check("t5_req_lo", 32'(mem_req), 32'd0);
    give_ack(16'h4444);
    check("t5_d0_new", 32'(rq0_dout), 32'h44);
    wait_req(22'h007003, "t5_r1");
    give_ack(16'h5555);
    wait_req(22'h008001, "t5_r2");
    give_ack(16'h6666);

    // Translation wrap at the top of the word space
    rq2_addr = 23'h7FFFFF;
    wait_req(22'h007FFF, "t6_wrap");
    give_ack(16'hA55A);
    check("t6_v2", 32'(rq2_valid), 32'd1);
    check("t6_d2", 32'(rq2_dout), 32'hA5);
    idle_cycles(5);
    check("t6_quiet", 32'(mem_req), 32'(exp_req));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rom_rd_arb.md
Name: rom_rd_arb

Overview:
- Shares one toggle-handshake SDRAM read port between three ROM requesters:
  - 0 = main CPU program ROM
  - 1 = sound CPU ROM
  - 2 = wave sample ROM
- Each requester presents a byte address continuously and receives a byte plus a valid flag.
- The block keeps a one-word (16-bit) cache per requester, detects word-address changes, and arbitrates fetches round-robin.
- It sits between the game top-level ROM buses and the SDRAM controller, and is gated off during ROM download.

Parameters:
- AW, 22, SDRAM word-address width.
- BASE0, 22'h000000, word offset added to requester 0 address.
- BASE1, 22'h007000, word offset added to requester 1 address.
- BASE2, 22'h008000, word offset added to requester 2 address.

Ports:
- clk_sys  in  1  system clock (48 MHz domain).
- reset  in  1  synchronous, active-high reset.
- dl_busy  in  1  ROM download in progress; ROM contents are unstable.
- rq0_addr, rq1_addr, rq2_addr  in  AW+1 each  byte address; bit 0 selects the byte within the word.
- rq0_dout, rq1_dout, rq2_dout  out  8 each  selected byte of the cached word.
- rq0_valid, rq1_valid, rq2_valid  out  1 each  cached word matches the current address.
- mem_req  out  1  toggle request to the SDRAM port.
- mem_ack  in  1  toggle acknowledge; the transaction is complete when mem_ack == mem_req.
- mem_addr  out  AW  word address of the current fetch.
- mem_q  in  16  read data; valid when the ack toggle is seen.

Behaviour:
- Interface: one clock, clk_sys. Reset is synchronous and active-high, on port reset.
- Per requester i, registered state: cache word D[i] (16b), tag T[i] (AW b), tag-valid V[i].
- Combinational outputs:
  - rqi_valid = V[i] & (T[i] == rqi_addr[AW:1]).
  - rqi_dout = rqi_addr[0] ? D[i][15:8] : D[i][7:0].
  - Both update in the same cycle as an address change.
- pending[i] = ~rqi_valid.
- Effective fetch address: rqi_addr[AW:1] + BASEi, truncated to AW bits; wraps modulo 2^AW.
- Round-robin pointer rr (2b, values 0..2): the search order is rr, rr+1, rr+2 (mod 3). The first pending requester wins.
- FSM states: RESYNC, IDLE, WAIT.
  - IDLE, when dl_busy=0 and any pending:
    - latch grant g and issue word ia = rqg_addr[AW:1] (untranslated).
    - mem_addr <= translated ia; toggle mem_req; go to WAIT.
    - Request is issued one cycle after pending is seen.
  - IDLE, with no pending or dl_busy=1: stay.
  - WAIT, when mem_ack == mem_req:
    - D[g] <= mem_q; T[g] <= ia; V[g] <= ~dl_busy.
    - rr <= g+1 mod 3; go to IDLE.
    - rqg_valid rises the following cycle if the address is unchanged.
  - WAIT, otherwise: hold. There is no timeout.
  - RESYNC: wait until mem_ack == mem_req, then go to IDLE.
- Address changes while waiting: if rqg_addr changes during WAIT, the fetched word is still cached under the old tag. valid stays 0 and the requester re-arbitrates.
- Simultaneous pending: round-robin guarantees each pending requester is served within 3 transactions.
- dl_busy=1:
  - V[*] cleared every cycle.
  - No new issue.
  - An in-flight fetch completes and is discarded (V stays 0).
- Reset (any state, including mid-WAIT):
  - V[*]=0, D[*]=0, T[*]=0, rr=0, mem_addr=0, state <= RESYNC.
  - mem_req is NOT altered by reset, so an outstanding toggle is drained before reuse. Power-up initial value of mem_req is 0.
  - All rq*_valid = 0 after reset.
  - rq*_dout = 0.
- Fetch latency (IDLE with pending to valid): 2 + SDRAM ack latency.

Test Plan:
- Reset, mem_ack=0; rq0_addr=0x00011 → mem_req toggles 0→1 with mem_addr=0x000008. Ack with mem_q=0xBEEF → next cycle rq0_valid=1, rq0_dout=0xBE. Set rq0_addr=0x00010 → rq0_dout=0xEF immediately, no new request.
- All three pending at once (rr=0; rq1_addr=0x0004 → mem_addr=0x007002; rq2 any) → grant order 0,1,2, one transaction each. All valid after 3 acks.
- rq1_addr changes from 0x0004 to 0x0006 during WAIT → after ack rq1_valid stays 0. Second fetch issued with mem_addr=0x007003.
- dl_busy=1 during a WAIT and with 2 cached requesters → all valid=0. No mem_req toggle after the ack. Fetches resume when dl_busy=0.
- Reset asserted in WAIT, then released with ack not yet returned → mem_req holds at 1 and no new toggle. Return ack=1 → IDLE, then normal fetch toggles mem_req to 0.
- rq2_addr word 0x3FFFFF with BASE2=0x008000 → mem_addr=0x007FFF (wrap).
